eq1_master: RTL and testbench



---
 rtl/eq1_pkg.sv | 28 ++
 rtl/eq1_master.sv | 173 +++++++++++++++++
 tb/tb_eq1_master.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/eq1_pkg.sv
// Shared types and constants for the eq1 bus master and its four-register slave.
package eq1_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      RD   = 3'd2,
      VRD  = 3'd3,
      TURN = 3'd4,
      DONE = 3'd5
   } eq1_state_t;

   localparam logic RW_READ      = 1'b0;
   localparam logic RW_WRITE     = 1'b1;
   localparam int   EQ1_NUM_REGS = 4;
   localparam int   EQ1_DEC_BITS = 2;

   // Bus cycle states, in which ce is asserted towards eq1
   function automatic logic is_access(eq1_state_t s);
      logic r;
      case (s)
         WR, RD, VRD: r = 1'b1;
         default:     r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/eq1_master.sv
// Bus master for the eq1 register file: turns a req/ack host request into ce/rw/address cycles.
// Optional write read-back verification is enabled with `define EQ1_MASTER_VERIFY_EN.
module eq1_master
   import eq1_pkg::*;
#(
   parameter int D_SIZE = 8,
   parameter int A_SIZE = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [A_SIZE-1:0] addr,
   input  logic [D_SIZE-1:0] wdata,
   output logic              ready,
   output logic              ack,
   output logic [D_SIZE-1:0] rdata,
   output logic              err,
   output logic              mismatch,
   inout  wire  [D_SIZE-1:0] data,
   output logic [A_SIZE-1:0] address,
   output logic              rw,
   output logic              ce
);

   eq1_state_t        state_q, state_d;
   eq1_state_t        turn_nxt_q, turn_nxt_d;
   logic [A_SIZE-1:0] addr_q;
   logic [D_SIZE-1:0] wdata_q;
   logic [D_SIZE-1:0] rdata_q;
   logic              ce_q, ce_d;
   logic              rw_q, rw_d;
   logic              drv_q, drv_d;
   logic              ready_q, ready_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              accept_s;
   logic              mapped_s;

   function automatic logic addr_mapped(logic [A_SIZE-1:0] a);
      return (a >> EQ1_DEC_BITS) == {A_SIZE{1'b0}};
   endfunction

   assign accept_s = (state_q == IDLE) && req;
   assign mapped_s = addr_mapped(addr);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= TURN;
         turn_nxt_q <= IDLE;
      end else begin
         state_q    <= state_d;
         turn_nxt_q <= turn_nxt_d;
      end
   end

   // TURN is shared by every path; turn_nxt remembers where it leads
   always_comb begin
      state_d    = state_q;
      turn_nxt_d = turn_nxt_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (!mapped_s) begin
                  state_d = DONE;
               end else if (we) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WR: begin
            state_d = TURN;
`ifdef EQ1_MASTER_VERIFY_EN
            turn_nxt_d = VRD;
`else
            turn_nxt_d = DONE;
`endif
         end
         RD: begin
            state_d    = TURN;
            turn_nxt_d = DONE;
         end
         VRD: begin
            state_d    = TURN;
            turn_nxt_d = DONE;
         end
         TURN:    state_d = turn_nxt_q;
         DONE:    state_d = IDLE;
         default: state_d = TURN;
      endcase
   end

   // Outputs are precomputed from the next state so they register cleanly
   always_comb begin
      ce_d    = is_access(state_d);
      rw_d    = (state_d == WR) ? RW_WRITE : RW_READ;
      drv_d   = (state_d == WR);
      ready_d = (state_d == IDLE);
      ack_d   = (state_d == DONE);
      err_d   = accept_s && !mapped_s;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ce_q    <= 1'b0;
         rw_q    <= RW_READ;
         drv_q   <= 1'b0;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ce_q    <= ce_d;
         rw_q    <= rw_d;
         drv_q   <= drv_d;
         ready_q <= ready_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q  <= {A_SIZE{1'b0}};
         wdata_q <= {D_SIZE{1'b0}};
         rdata_q <= {D_SIZE{1'b0}};
      end else begin
         if (accept_s && mapped_s) begin
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (state_q == RD) begin
            rdata_q <= data;
         end
      end
   end

`ifdef EQ1_MASTER_VERIFY_EN
   logic mism_flag_q;
   logic mismatch_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mism_flag_q <= 1'b0;
         mismatch_q  <= 1'b0;
      end else begin
         if (accept_s) begin
            mism_flag_q <= 1'b0;
         end else if (state_q == VRD) begin
            mism_flag_q <= (data != wdata_q);
         end
         mismatch_q <= (state_d == DONE) && mism_flag_q && !accept_s;
      end
   end

   assign mismatch = mismatch_q;
`else
   assign mismatch = 1'b0;
`endif

   assign data    = drv_q ? wdata_q : {D_SIZE{1'bz}};
   assign address = addr_q;
   assign rw      = rw_q;
   assign ce      = ce_q;
   assign ready   = ready_q;
   assign ack     = ack_q;
   assign err     = err_q;
   assign rdata   = rdata_q;

endmodule

// File: tb/tb_eq1_master.sv
// Directed bench for eq1_master (A_SIZE=3) with a behavioural eq1 slave on the shared bus.
module tb_eq1_master;

`ifdef EQ1_MASTER_VERIFY_EN
   localparam bit VFY = 1'b1;
`else
   localparam bit VFY = 1'b0;
`endif
   localparam int WLAT = VFY ? 5 : 3;
   localparam int WCE  = VFY ? 2 : 1;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req   = 1'b0;
   logic       we    = 1'b0;
   logic [2:0] addr  = 3'd0;
   logic [7:0] wdata = 8'h00;
   logic       ready, ack, err, mismatch, rw, ce;
   logic [7:0] rdata;
   logic [2:0] address;
   wire  [7:0] data;

   always #5 clock = ~clock;

   eq1_master #(.D_SIZE(8), .A_SIZE(3)) dut (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ready(ready), .ack(ack), .rdata(rdata), .err(err), .mismatch(mismatch),
      .data(data), .address(address), .rw(rw), .ce(ce)
   );

   // eq1 slave: acts on negedge, keeps driving after a read until a negedge with ce=0
   logic [7:0] sl_mem [0:3] = '{8'h00, 8'h3C, 8'h00, 8'h00};
   logic       sl_drv       = 1'b0;
   logic [7:0] sl_q         = 8'h00;
   logic       corrupt      = 1'b0;
   int         overlap_cnt  = 0;

   always @(negedge clock) begin
      if (ce && rw) begin
         if (sl_drv) overlap_cnt <= overlap_cnt + 1;
         sl_mem[address[1:0]] <= data;
         sl_drv <= 1'b0;
      end else if (ce) begin
         sl_drv <= 1'b1;
         sl_q   <= corrupt ? 8'h00 : sl_mem[address[1:0]];
      end else begin
         sl_drv <= 1'b0;
      end
   end

   assign data = sl_drv ? sl_q : 8'bz;
   pullup (data);

   int n_cmp  = 0;
   int n_fail = 0;
   logic [7:0] exp_rd = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       we;
      logic [2:0] addr;
      logic [7:0] wdata;
      logic       corrupt;
      logic       exp_err;
      logic       exp_mism;
      logic [7:0] exp_rdval;
   } vec_t;

   task automatic wait_ready();
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (ready) break;
      end
      if (!ready) check("ready_wait", 32'(ready), 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int lat, ce_n, exp_lat, exp_ce;
      lat = 0; ce_n = 0;
      wait_ready();
      req = 1'b1; we = v.we; addr = v.addr;
      wdata = v.we ? v.wdata : 8'hFF;
      corrupt = v.corrupt;
      @(posedge clock); #1;
      req = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         if (ce) begin
            ce_n++;
            check("bus_address", 32'(address), 32'(v.addr));
            if (rw) check("wr_bus_data", 32'(data), 32'(v.wdata));
         end
         if (ack) begin
            lat = n;
            break;
         end
         @(posedge clock); #1;
      end
      if (v.exp_err) begin
         exp_lat = 1; exp_ce = 0;
      end else if (v.we) begin
         exp_lat = WLAT; exp_ce = WCE;
      end else begin
         exp_lat = 3; exp_ce = 1;
         exp_rd  = v.exp_rdval;
      end
      check("ack_latency", 32'(lat), 32'(exp_lat));
      check("ce_cycles", 32'(ce_n), 32'(exp_ce));
      check("err", 32'(err), 32'(v.exp_err));
      check("mismatch", 32'(mismatch), 32'(v.exp_mism));
      check("rdata", 32'(rdata), 32'(exp_rd));
      check("bus_released_done", 32'(data), 32'hFF);
      corrupt = 1'b0;
      @(posedge clock); #1;
      check("ack_one_cycle", 32'(ack), 32'd0);
   endtask

   vec_t tbl [11];
   vec_t post [3];

   initial begin
      tbl[0]  = '{1'b1, 3'd2, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5};
      tbl[2]  = '{1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C};
      tbl[3]  = '{1'b1, 3'd1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[4]  = '{1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A};
      tbl[5]  = '{1'b0, 3'd6, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[6]  = '{1'b1, 3'd7, 8'h99, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[7]  = '{1'b1, 3'd3, 8'hF0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[8]  = '{1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'hF0};
      tbl[9]  = '{1'b1, 3'd3, 8'hF0, 1'b1, 1'b0, VFY,  8'h00};
      tbl[10] = '{1'b0, 3'd4, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
      post[0] = '{1'b1, 3'd0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00};
      post[1] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h11};
      post[2] = '{1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5};

      // reset values and ready timing after release
      repeat (3) @(posedge clock);
      #1;
      check("rst_ce", 32'(ce), 32'd0);
      check("rst_rw", 32'(rw), 32'd0);
      check("rst_address", 32'(address), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_mismatch", 32'(mismatch), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_data_z", 32'(data), 32'hFF);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("ready_first_cycle", 32'(ready), 32'd0);
      @(posedge clock); #1;
      check("ready_after_turn", 32'(ready), 32'd1);
      check("ce_after_turn", 32'(ce), 32'd0);

      for (int i = 0; i < 11; i++) run_vec(tbl[i]);
      check("no_bus_overlap", 32'(overlap_cnt), 32'd0);

      // reset during RD
      wait_ready();
      req = 1'b1; we = 1'b0; addr = 3'd1; wdata = 8'hFF;
      @(posedge clock); #1;
      req = 1'b0;
      check("rd_ce_before_rst", 32'(ce), 32'd1);
      @(negedge clock); #1;
      reset = 1'b1;
      #1;
      check("rst_in_rd_ce", 32'(ce), 32'd0);
      check("rst_in_rd_ready", 32'(ready), 32'd0);
      exp_rd = 8'h00;
      @(negedge clock);
      reset = 1'b0;

      // reset during WR releases the master's driver at once
      wait_ready();
      req = 1'b1; we = 1'b1; addr = 3'd2; wdata = 8'h77;
      @(posedge clock); #1;
      req = 1'b0;
      check("wr_drive_before_rst", 32'(data), 32'h77);
      reset = 1'b1;
      #1;
      check("rst_in_wr_data_z", 32'(data), 32'hFF);
      check("rst_in_wr_ce", 32'(ce), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 3; i++) run_vec(post[i]);
      check("no_bus_overlap_end", 32'(overlap_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

endmodule
